// File: rtl/can_tx_if.sv
// can_tx_if: frame request, bus readback and status signals of the CAN transmitter.
interface can_tx_if;
  logic        i_Tx_DV;
  logic        i_Tx_Extended;
  logic        i_Tx_Remote;
  logic [28:0] i_Tx_ID;
  logic [3:0]  i_Tx_DLC;
  logic [63:0] i_Tx_Data;
  logic        i_Rx_Serial;
  logic        o_Tx_Serial;
  logic        o_Tx_Active;
  logic        o_Tx_Done;
  logic        o_Tx_Ack;

  // Transmitter side
  modport slave (
    input  i_Tx_DV, i_Tx_Extended, i_Tx_Remote, i_Tx_ID, i_Tx_DLC, i_Tx_Data, i_Rx_Serial,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ack
  );

  // Requester side
  modport master (
    output i_Tx_DV, i_Tx_Extended, i_Tx_Remote, i_Tx_ID, i_Tx_DLC, i_Tx_Data, i_Rx_Serial,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ack
  );
endinterface

// File: rtl/can_tx.sv
// can_tx: serializes a CAN frame (no bit stuffing) with CRC-15 and ACK-slot sampling.
module can_tx #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input logic       i_Clock,
  input logic       i_Reset,
  can_tx_if.slave   bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ACK_SAMPLE = CNT_W'((CLKS_PER_BIT - 1) / 2);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SOF      = 4'd1;
  localparam logic [3:0] S_ID_A     = 4'd2;
  localparam logic [3:0] S_CTRL_STD = 4'd3;
  localparam logic [3:0] S_SRR_IDE  = 4'd4;
  localparam logic [3:0] S_ID_B     = 4'd5;
  localparam logic [3:0] S_CTRL_EXT = 4'd6;
  localparam logic [3:0] S_DLC      = 4'd7;
  localparam logic [3:0] S_DATA     = 4'd8;
  localparam logic [3:0] S_CRC      = 4'd9;
  localparam logic [3:0] S_CRC_DEL  = 4'd10;
  localparam logic [3:0] S_ACK_SLOT = 4'd11;
  localparam logic [3:0] S_ACK_DEL  = 4'd12;
  localparam logic [3:0] S_EOF      = 4'd13;
  localparam logic [3:0] S_IFS      = 4'd14;

  logic [3:0]       state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [14:0]      crc_q, crc_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             ext_q, ext_d;
  logic             rtr_q, rtr_d;
  logic [28:0]      id_q, id_d;
  logic [3:0]       dlc_q, dlc_d;
  logic [63:0]      data_q, data_d;
  logic [3:0]       nbytes_q, nbytes_d;

  logic [BIT_W-1:0] field_last_c;
  logic [3:0]       next_field_c;
  logic             next_bit_c;

  // One CRC-15 step (poly 0x4599) for a single transmitted bit
  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    return {crc[13:0], 1'b0} ^ (((crc[14] ^ b) == 1'b1) ? 15'h4599 : 15'h0000);
  endfunction

  // Value on the line for bit idx of field st
  function automatic logic bit_sel(input logic [3:0] st, input logic [BIT_W-1:0] idx,
                                   input logic ext, input logic rtr, input logic [28:0] id,
                                   input logic [3:0] dlc, input logic [63:0] data,
                                   input logic [14:0] crc);
    logic b;
    b = 1'b1;
    case (st)
      S_SOF:      b = 1'b0;
      S_ID_A:     b = ext ? id[5'd28 - idx[4:0]] : id[5'd10 - idx[4:0]];
      S_CTRL_STD,
      S_CTRL_EXT: b = (idx == '0) ? rtr : 1'b0;
      S_SRR_IDE:  b = 1'b1;
      S_ID_B:     b = id[5'd17 - idx[4:0]];
      S_DLC:      b = dlc[2'd3 - idx[1:0]];
      S_DATA:     b = data[6'd63 - idx];
      S_CRC:      b = crc[4'd14 - idx[3:0]];
      default:    b = 1'b1;
    endcase
    return b;
  endfunction

  // Fields whose bits feed the CRC (SOF is always 0 and leaves a zero CRC unchanged)
  function automatic logic crc_field(input logic [3:0] st);
    return (st == S_ID_A) || (st == S_CTRL_STD) || (st == S_SRR_IDE) || (st == S_ID_B) ||
           (st == S_CTRL_EXT) || (st == S_DLC) || (st == S_DATA);
  endfunction

  // Index of the last bit in the current field
  always_comb begin
    field_last_c = '0;
    case (state_q)
      S_ID_A:     field_last_c = BIT_W'(10);
      S_CTRL_STD,
      S_CTRL_EXT: field_last_c = BIT_W'(2);
      S_SRR_IDE:  field_last_c = BIT_W'(1);
      S_ID_B:     field_last_c = BIT_W'(17);
      S_DLC:      field_last_c = BIT_W'(3);
      S_DATA:     field_last_c = BIT_W'({nbytes_q, 3'b000} - 7'd1);
      S_CRC:      field_last_c = BIT_W'(14);
      S_EOF:      field_last_c = BIT_W'(6);
      S_IFS:      field_last_c = BIT_W'(2);
      default:    field_last_c = '0;
    endcase
  end

  // Field that follows the current one
  always_comb begin
    next_field_c = S_IDLE;
    case (state_q)
      S_SOF:      next_field_c = S_ID_A;
      S_ID_A:     next_field_c = ext_q ? S_SRR_IDE : S_CTRL_STD;
      S_CTRL_STD: next_field_c = S_DLC;
      S_SRR_IDE:  next_field_c = S_ID_B;
      S_ID_B:     next_field_c = S_CTRL_EXT;
      S_CTRL_EXT: next_field_c = S_DLC;
      S_DLC:      next_field_c = (nbytes_q == 4'd0) ? S_CRC : S_DATA;
      S_DATA:     next_field_c = S_CRC;
      S_CRC:      next_field_c = S_CRC_DEL;
      S_CRC_DEL:  next_field_c = S_ACK_SLOT;
      S_ACK_SLOT: next_field_c = S_ACK_DEL;
      S_ACK_DEL:  next_field_c = S_EOF;
      S_EOF:      next_field_c = S_IFS;
      default:    next_field_c = S_IDLE;
    endcase
  end

  // Next state, counters and registered outputs; a new bit is launched when the bit time expires
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    ack_d      = ack_q;
    ext_d      = ext_q;
    rtr_d      = rtr_q;
    id_d       = id_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    next_bit_c = 1'b1;

    if (state_q == S_IDLE) begin
      if (bus.i_Tx_DV) begin
        ext_d    = bus.i_Tx_Extended;
        rtr_d    = bus.i_Tx_Remote;
        id_d     = bus.i_Tx_ID;
        dlc_d    = bus.i_Tx_DLC;
        data_d   = bus.i_Tx_Data;
        if (bus.i_Tx_Remote)
          nbytes_d = 4'd0;
        else if (bus.i_Tx_DLC > 4'd8)
          nbytes_d = 4'd8;
        else
          nbytes_d = bus.i_Tx_DLC;
        state_d  = S_SOF;
        bit_d    = '0;
        cnt_d    = '0;
        crc_d    = '0;
        serial_d = 1'b0;
        active_d = 1'b1;
        ack_d    = 1'b0;
      end
    end else begin
      if ((state_q == S_ACK_SLOT) && (cnt_q == ACK_SAMPLE) && !bus.i_Rx_Serial)
        ack_d = 1'b1;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (bit_q == field_last_c) begin
          bit_d   = '0;
          state_d = next_field_c;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
        if (state_d == S_IDLE) begin
          serial_d = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          next_bit_c = bit_sel(state_d, bit_d, ext_q, rtr_q, id_q, dlc_q, data_q, crc_q);
          serial_d   = next_bit_c;
          if (crc_field(state_d))
            crc_d = crc_step(crc_q, next_bit_c);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      ext_q    <= 1'b0;
      rtr_q    <= 1'b0;
      id_q     <= '0;
      dlc_q    <= '0;
      data_q   <= '0;
      nbytes_q <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      ext_q    <= ext_d;
      rtr_q    <= rtr_d;
      id_q     <= id_d;
      dlc_q    <= dlc_d;
      data_q   <= data_d;
      nbytes_q <= nbytes_d;
    end
  end

  assign bus.o_Tx_Serial = serial_q;
  assign bus.o_Tx_Active = active_q;
  assign bus.o_Tx_Done   = done_q;
  assign bus.o_Tx_Ack    = ack_q;

endmodule
